// File: rtl/data_structures.sv
// Shared types and constants for the fetch queue: FSM states, queue entry layout
// and the HLT instruction match pattern.
package data_structures;

  typedef enum logic [1:0] {
    FQ_FETCH,
    FQ_DRAIN,
    FQ_DONE
  } fq_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
  } fq_entry_t;

  // HLT: bits[31:21] = 11010100010, bits[4:0] = 00000, immediate bits ignored
  localparam logic [31:0] HLT_MASK  = 32'hFFE0_001F;
  localparam logic [31:0] HLT_VALUE = 32'hD440_0000;

  function automatic logic is_hlt(input logic [31:0] word);
    return (word & HLT_MASK) == HLT_VALUE;
  endfunction

endpackage

// File: rtl/fq_ring.sv
// Circular buffer of fetched {pc, insn} entries: power-of-two depth, wrapping
// head/tail pointers, occupancy count, and a clear that outranks push/pop.
module fq_ring
  import data_structures::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  fq_entry_t              wdata,
  output fq_entry_t              rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fq_entry_t         mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[head];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[tail] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst || clear)
    !(push && full && !pop));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues one-cycle-latency imem reads, buffers the
// returned words in order, and stops fetching once an HLT has been delivered.
module fetch_queue
  import data_structures::*;
#(
  parameter int unsigned IQ_DEPTH = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_stall,
  input  logic        in_redirect,
  input  logic [63:0] in_redirect_pc,
  output logic        out_imem_req,
  output logic [63:0] out_imem_addr,
  input  logic        in_imem_valid,
  input  logic [31:0] in_imem_rdata,
  output logic [31:0] out_insnbits,
  output logic [63:0] out_pc,
  output logic        out_valid,
  output logic        out_fetch_done
);

  localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

  fq_state_e   state;
  fq_state_e   next_state;
  logic [63:0] fetch_pc;
  logic [63:0] req_pc;
  logic        inflight;
  logic        req_epoch;
  logic        epoch;
  logic        done_q;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic        empty;
  fq_entry_t   head;
  fq_entry_t   tail_entry;
  logic        resp_ok;
  logic        push;
  logic        pop;

  fq_ring #(.DEPTH(IQ_DEPTH)) u_ring (
    .clk   (in_clk),
    .rst   (in_rst),
    .clear (in_redirect),
    .push  (push),
    .pop   (pop),
    .wdata (tail_entry),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= FQ_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (in_redirect) begin
      next_state = FQ_FETCH;
    end else begin
      unique case (state)
        FQ_FETCH: if (push && is_hlt(in_imem_rdata)) next_state = FQ_DRAIN;
        FQ_DRAIN: if (pop && is_hlt(head.insn))      next_state = FQ_DONE;
        FQ_DONE:  next_state = FQ_DONE;
        default:  next_state = FQ_FETCH;
      endcase
    end
  end

  always_comb begin
    occupancy      = {1'b0, count} + {{CW{1'b0}}, inflight};
    out_imem_req   = (state == FQ_FETCH) && !in_redirect && !in_rst &&
                     (occupancy < (CW+1)'(IQ_DEPTH));
    out_imem_addr  = fetch_pc;
    // Words returning after HLT (or from an older epoch) are never queued.
    resp_ok        = in_imem_valid && inflight && (req_epoch == epoch) &&
                     (state == FQ_FETCH);
    push           = resp_ok && !in_redirect;
    pop            = !empty && !in_stall && !in_redirect;
    tail_entry     = '{pc: req_pc, insn: in_imem_rdata};
    out_valid      = !empty;
    out_insnbits   = empty ? '0 : head.insn;
    out_pc         = empty ? '0 : head.pc;
    out_fetch_done = done_q;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      inflight  <= 1'b0;
      req_epoch <= 1'b0;
      epoch     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= (next_state == FQ_DONE);
      inflight <= out_imem_req;
      if (out_imem_req) begin
        req_pc    <= fetch_pc;
        req_epoch <= epoch;
      end
      if (in_redirect) begin
        fetch_pc <= in_redirect_pc;
        epoch    <= ~epoch;
      end else if (out_imem_req) begin
        fetch_pc <= fetch_pc + 64'd4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// stall/redirect traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] rpc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] insnbits;
  logic [63:0] pc;
  logic        valid;
  logic        fetch_done;

  fetch_queue #(.IQ_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_stall       (stall),
    .in_redirect    (redirect),
    .in_redirect_pc (rpc),
    .out_imem_req   (imem_req),
    .out_imem_addr  (imem_addr),
    .in_imem_valid  (imem_valid),
    .in_imem_rdata  (imem_rdata),
    .out_insnbits   (insnbits),
    .out_pc         (pc),
    .out_valid      (valid),
    .out_fetch_done (fetch_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  logic        m_pend;
  logic [63:0] m_pend_pc;
  logic        m_halt;
  logic        m_done;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc;
  int          first_valid;
  int          reqs;
  int          pops;
  int          saw10;
  logic        sent_req;
  logic [63:0] sent_addr;
  logic [63:0] hlt_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic ref_hlt(input logic [31:0] w);
    return (w[31:21] == 11'b11010100010) && (w[4:0] == 5'b00000);
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == hlt_addr) return 32'hD440_0000;
    return 32'hAA00_0000 | {8'h00, a[23:0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = 64'h0;
    m_pend = 1'b0;
    m_halt = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b1;
    rpc = 64'h500;
    stall = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hD440_0000;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", valid, 0);
    check("rst_done", fetch_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    redirect = 1'b0;
    // A response right after reset must be discarded.
    imem_valid = 1'b1;
    imem_rdata = 32'hD440_0000;
    model_reset();
    cyc = 0;
    first_valid = -1;
  endtask

  task automatic step();
    logic exp_req;
    ent_t e;
    @(negedge clk);
    exp_req = !m_halt && !redirect && ((mq.size() + int'(m_pend)) < DEPTH);
    check("req", imem_req, exp_req);
    if (exp_req) check("addr", imem_addr, m_pc);
    check("valid", valid, mq.size() > 0);
    check("head_pc", pc, (mq.size() > 0) ? mq[0].pc : 64'h0);
    check("head_insn", insnbits, (mq.size() > 0) ? {32'h0, mq[0].insn} : 64'h0);
    check("done", fetch_done, m_done);
    sent_req  = imem_req;
    sent_addr = imem_addr;
    if (imem_req) reqs++;
    if (imem_req && imem_addr == 64'h10) saw10++;
    if (valid && !stall) pops++;
    if (valid && first_valid < 0) first_valid = cyc;
    if (redirect) begin
      mq.delete();
      m_pc   = rpc;
      m_pend = 1'b0;
      m_halt = 1'b0;
      m_done = 1'b0;
    end else begin
      if (mq.size() > 0 && !stall) begin
        e = mq.pop_front();
        if (ref_hlt(e.insn)) m_done = 1'b1;
      end
      if (imem_valid && m_pend && !m_halt) begin
        mq.push_back('{pc: m_pend_pc, insn: imem_rdata});
        if (ref_hlt(imem_rdata)) m_halt = 1'b1;
      end
      if (exp_req) begin
        m_pend    = 1'b1;
        m_pend_pc = m_pc;
        m_pc      = m_pc + 64'd4;
      end else begin
        m_pend = 1'b0;
      end
    end
    @(posedge clk); #1;
    imem_valid = sent_req;
    imem_rdata = mem_word(sent_addr);
    cyc++;
  endtask

  initial begin
    logic got;

    // Straight-line fetch of plain words
    hlt_addr = '1;
    do_reset();
    for (int i = 0; i < 12; i++) step();
    check("first_valid_cycle", 64'(first_valid), 2);

    // Dispatch stalled: queue fills to depth then requests stop
    do_reset();
    stall = 1'b1;
    reqs = 0;
    for (int i = 0; i < 10; i++) step();
    check("stall_reqs", 64'(reqs), DEPTH);
    stall = 1'b0;
    pops = 0;
    for (int i = 0; i < 4; i++) step();
    check("release_pops", 64'(pops), 4);

    // Redirect with a response in flight
    for (int i = 0; i < 10; i++) begin
      step();
      if (sent_req) break;
    end
    redirect = 1'b1;
    rpc = 64'h1000;
    step();
    redirect = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (valid && !got) begin
        check("redirect_pc", pc, 64'h1000);
        got = 1'b1;
      end
    end
    check("redirect_seen", got, 1);

    // HLT at 0x8
    hlt_addr = 64'h8;
    do_reset();
    saw10 = 0;
    for (int i = 0; i < 15; i++) step();
    check("no_req_0x10", 64'(saw10), 0);
    check("halt_done", fetch_done, 1);

    // Redirect out of DONE
    redirect = 1'b1;
    rpc = 64'h40;
    step();
    redirect = 1'b0;
    check("done_cleared", fetch_done, 0);
    for (int i = 0; i < 8; i++) step();

    // Randomized traffic, including 64-bit PC wrap
    hlt_addr = 64'(4 * $urandom_range(4, 40));
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      stall    = ($urandom % 3) == 0;
      redirect = ($urandom % 40) == 0;
      if (($urandom % 8) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      else                     rpc = 64'(4 * $urandom_range(0, 30));
      step();
    end
    redirect = 1'b0;
    stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter IQ_DEPTH, default 4, sets the instruction queue entry count (power of two, minimum 2).
REQ-002 Parameter RESET_PC, default 64'h0, sets the first fetch address after reset.
REQ-003 Port in_clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 Port in_rst, input, width 1: reset, synchronous and active-high.
REQ-005 Port in_stall, input, width 1: dispatch cannot accept an instruction this cycle.
REQ-006 Port in_redirect, input, width 1: flush the queue and restart fetch.
REQ-007 Port in_redirect_pc, input, width 64: restart address, valid with in_redirect.
REQ-008 Port out_imem_req, output, width 1: instruction memory read request.
REQ-009 Port out_imem_addr, output, width 64: request address, valid with out_imem_req.
REQ-010 Port in_imem_valid, input, width 1: read data returned.
REQ-011 Port in_imem_rdata, input, width 32: returned instruction word.
REQ-012 Port out_insnbits, output, width 32: instruction bits at the queue head, to dispatch.
REQ-013 Port out_pc, output, width 64: PC of the queue head.
REQ-014 Port out_valid, output, width 1: the queue head holds an instruction.
REQ-015 Port out_fetch_done, output, width 1: the halt instruction has been delivered and fetch has stopped.

Function
REQ-016 Instruction memory latency SHALL be exactly one cycle: a request in cycle N is answered by in_imem_valid in cycle N+1, at most one response per cycle.
REQ-017 out_imem_req SHALL assert only when state is FETCH, in_redirect is low, and (queue count + in-flight count) < IQ_DEPTH.
REQ-018 On each issued request, fetch PC SHALL advance by 4 with 64-bit wrap-around.
REQ-019 A valid response SHALL be pushed at the tail as the pair {request PC, in_imem_rdata}.
REQ-020 Pop SHALL occur when out_valid and !in_stall; push and pop in the same cycle leave count unchanged.
REQ-021 out_insnbits and out_pc SHALL be combinational from the head entry; both SHALL be zero when out_valid is low.
REQ-022 States: FETCH, DRAIN, DONE.
REQ-023 Transition FETCH->DRAIN when the pushed word matches the HLT pattern (bits[31:21]=11010100010, bits[4:0]=00000); no further requests issue.
REQ-024 Transition DRAIN->DONE in the cycle the HLT entry is popped.
REQ-025 out_fetch_done SHALL be high only in DONE and SHALL be registered.
REQ-026 in_redirect SHALL have priority over every other event: same edge clears the queue, sets fetch PC to in_redirect_pc, enters FETCH from any state, and ignores a simultaneous pop.
REQ-027 A response to a request issued before a redirect SHALL be discarded, tracked by a 1-bit epoch toggled on redirect.
REQ-028 Queue overflow SHALL be impossible; the push-to-full case is covered by a simulation assertion.
REQ-029 An instruction that does not decode as HLT SHALL never change state.

Reset
REQ-030 On in_rst: fetch PC=RESET_PC, queue empty, in-flight=0, epoch=0, state=FETCH, out_fetch_done=0, out_valid=0, out_imem_req=0 during the reset cycle.
REQ-031 in_rst SHALL override in_redirect; a response arriving in the cycle after reset SHALL be discarded.

Structure
REQ-032 The state enum (FQ_FETCH, FQ_DRAIN, FQ_DONE) and the HLT match mask/value constants SHALL live in the shared package data_structures.sv.
REQ-033 One sub-module, fq_ring, SHALL implement the circular buffer: head/tail pointers with wrap, count, push, pop, and clear.

Verification
REQ-034 Reset, then NOPs returned, in_stall=0 -> requests at 0x0, 0x4, 0x8, ...; out_pc sequence 0x0, 0x4, 0x8, ...; first out_valid two cycles after reset release.
REQ-035 in_stall=1 held for 10 cycles -> exactly IQ_DEPTH=4 requests outstanding or queued, then out_imem_req=0; on release, 4 pops in 4 cycles with no loss.
REQ-036 Redirect to 0x1000 while a response is in flight -> the stale response is dropped; next request at 0x1000; next out_pc=0x1000.
REQ-037 HLT (0xD4400000) at 0x8 -> no request for 0x10 after HLT returns; out_fetch_done=1 the cycle after HLT is popped; stays 1.
REQ-038 Redirect in DONE to 0x40 -> out_fetch_done=0 next cycle; fetch resumes at 0x40.
REQ-039 Push and pop together with the queue at 3/4 -> count stays 3; FIFO order is preserved across pointer wrap.
